// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for an RV32I datapath: steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, drives datapath controls and counts retirements.
module mc_control_fsm #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       f3,
    input  logic [6:0]       f7,
    input  logic             mem_ready,
    output logic             ir_en,
    output logic             pc_en,
    output logic             reg_wr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [1:0]       wb_ctrl,
    output logic [3:0]       alu_op,
    output logic             alu_s1,
    output logic             alu_s2,
    output logic [2:0]       branch_ctrl,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int WAIT_W = (MEM_TIMEOUT > 32'sd1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 32'sd1);

    function automatic logic op_known(input logic [6:0] op);
        logic known;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: known = 1'b1;
            default:                                       known = 1'b0;
        endcase
        return known;
    endfunction

    function automatic logic [2:0] branch_code(input logic [2:0] fn3);
        logic [2:0] code;
        case (fn3)
            3'b000:  code = 3'b001;
            3'b001:  code = 3'b010;
            3'b100:  code = 3'b011;
            3'b101:  code = 3'b100;
            3'b110:  code = 3'b101;
            3'b111:  code = 3'b110;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    state_e            state_q, state_d;
    logic [6:0]        op_q;
    logic [2:0]        f3_q;
    logic              f7b5_q;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              halted_q, illegal_q;
    logic [CNT_W-1:0]  instret_q;

    logic latch_s, retire_s, set_halt_s, set_illegal_s;
    logic unused_f7_s;

    logic             ir_en_s, pc_en_s, reg_wr_s, mem_rd_s, mem_wr_s;
    logic [1:0]       wb_ctrl_s;
    logic [3:0]       alu_op_s;
    logic             alu_s1_s, alu_s2_s;
    logic [2:0]       branch_ctrl_s;

    assign unused_f7_s = ^{f7[6], f7[4:0]};

    // State, decode register, MEM wait counter, sticky flags and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= 7'd0;
            f3_q      <= 3'd0;
            f7b5_q    <= 1'b0;
            wait_q    <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (latch_s) begin
                op_q   <= opcode;
                f3_q   <= f3;
                f7b5_q <= f7[5];
            end
            if (set_halt_s)    halted_q  <= 1'b1;
            if (set_illegal_s) illegal_q <= 1'b1;
            if (retire_s)      instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Next-state logic, including MEM wait handling and retirement events.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        latch_s       = 1'b0;
        retire_s      = 1'b0;
        set_halt_s    = 1'b0;
        set_illegal_s = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                latch_s = 1'b1;
                if (!op_known(opcode)) begin
                    set_halt_s    = 1'b1;
                    set_illegal_s = 1'b1;
                    state_d       = S_HALT;
                end else if (opcode == OP_SYSTEM) begin
                    set_halt_s = 1'b1;
                    state_d    = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op_q == OP_BRANCH) begin
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end else if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
                    wait_d  = '0;
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (op_q == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        retire_s = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else if ((MEM_TIMEOUT != 32'sd0) && (wait_q == WAIT_LAST)) begin
                    set_halt_s    = 1'b1;
                    set_illegal_s = 1'b1;
                    state_d       = S_HALT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                retire_s = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Datapath control decode from the current state and latched instruction.
    always_comb begin
        ir_en_s       = 1'b0;
        pc_en_s       = 1'b0;
        reg_wr_s      = 1'b0;
        mem_rd_s      = 1'b0;
        mem_wr_s      = 1'b0;
        wb_ctrl_s     = 2'b00;
        alu_op_s      = 4'b0000;
        alu_s1_s      = 1'b0;
        alu_s2_s      = 1'b0;
        branch_ctrl_s = 3'b000;
        if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
            alu_s1_s = (op_q == OP_AUIPC) || (op_q == OP_JAL) || (op_q == OP_BRANCH);
            alu_s2_s = (op_q != OP_R);
            case (op_q)
                OP_R:    alu_op_s = {f7b5_q, f3_q};
                OP_I:    alu_op_s = (f3_q == 3'b101) ? {f7b5_q, f3_q} : {1'b0, f3_q};
                OP_LUI:  alu_op_s = 4'b1111;
                default: alu_op_s = 4'b0000;
            endcase
        end else begin
            alu_op_s = 4'b0000;
        end
        case (state_q)
            S_FETCH: ir_en_s = 1'b1;
            S_EXEC: begin
                if (op_q == OP_BRANCH) begin
                    branch_ctrl_s = branch_code(f3_q);
                    pc_en_s       = 1'b1;
                end else if ((op_q == OP_JAL) || (op_q == OP_JALR)) begin
                    branch_ctrl_s = 3'b111;
                end else begin
                    branch_ctrl_s = 3'b000;
                end
            end
            S_MEM: begin
                mem_rd_s = (op_q == OP_LOAD);
                mem_wr_s = (op_q == OP_STORE);
                pc_en_s  = (op_q == OP_STORE) && mem_ready;
            end
            S_WB: begin
                reg_wr_s = 1'b1;
                pc_en_s  = 1'b1;
                if (op_q == OP_LOAD) begin
                    wb_ctrl_s = 2'b00;
                end else if ((op_q == OP_JAL) || (op_q == OP_JALR)) begin
                    wb_ctrl_s = 2'b10;
                end else begin
                    wb_ctrl_s = 2'b01;
                end
            end
            default: ir_en_s = 1'b0;
        endcase
    end

    // Reset masks every output combinationally so an in-flight access drops at once.
    assign ir_en       = reset ? 1'b0   : ir_en_s;
    assign pc_en       = reset ? 1'b0   : pc_en_s;
    assign reg_wr      = reset ? 1'b0   : reg_wr_s;
    assign mem_rd      = reset ? 1'b0   : mem_rd_s;
    assign mem_wr      = reset ? 1'b0   : mem_wr_s;
    assign wb_ctrl     = reset ? 2'b00  : wb_ctrl_s;
    assign alu_op      = reset ? 4'b0000 : alu_op_s;
    assign alu_s1      = reset ? 1'b0   : alu_s1_s;
    assign alu_s2      = reset ? 1'b0   : alu_s2_s;
    assign branch_ctrl = reset ? 3'b000 : branch_ctrl_s;
    assign halted      = reset ? 1'b0   : halted_q;
    assign illegal     = reset ? 1'b0   : illegal_q;
    assign instret     = reset ? '0     : instret_q;

endmodule
